controlador_vendas: RTL

Vending-sequence controller for the coin accumulator. It takes a product selection and confirm/cancel requests, then checks the accumulated credit (`total`, in R$0,25 units) against the product price. It sequences dispensing, change return and clearing of the accumulator. It sits between the user-input front end and the accumulator/dispense/change datapath.

---
 rtl/controlador_vendas.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/controlador_vendas.sv
// Vending-sequence controller: checks accumulated credit against the selected
// product's price and sequences dispense, change return and accumulator clear.
module controlador_vendas #(
    parameter logic [3:0] PRECO_0     = 4'd3,
    parameter logic [3:0] PRECO_1     = 4'd4,
    parameter logic [3:0] PRECO_2     = 4'd6,
    parameter logic [3:0] PRECO_3     = 4'd8,
    parameter int         DISP_CICLOS = 4,
    parameter int         ERRO_CICLOS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] total,
    input  logic [1:0] sel,
    input  logic       confirma,
    input  logic       cancela,
    output logic [3:0] libera,
    output logic [3:0] troco,
    output logic       troco_valido,
    output logic       limpa_acum,
    output logic       erro_saldo,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISPENSE,
        S_REFUND,
        S_CHANGE,
        S_CLEAR,
        S_ERROR
    } estado_t;

    localparam logic [3:0] DISP_FIM = 4'(DISP_CICLOS - 1);
    localparam logic [3:0] ERRO_FIM = 4'(ERRO_CICLOS - 1);

    estado_t    estado_q, estado_d;
    logic [1:0] sel_reg_q, sel_reg_d;
    logic [3:0] preco_reg_q, preco_reg_d;
    logic [3:0] troco_reg_q, troco_reg_d;
    logic [3:0] cnt_q, cnt_d;

    function automatic logic [3:0] preco_de(input logic [1:0] s);
        case (s)
            2'd0:    preco_de = PRECO_0;
            2'd1:    preco_de = PRECO_1;
            2'd2:    preco_de = PRECO_2;
            default: preco_de = PRECO_3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= S_IDLE;
            sel_reg_q   <= '0;
            preco_reg_q <= '0;
            troco_reg_q <= '0;
            cnt_q       <= '0;
        end else begin
            estado_q    <= estado_d;
            sel_reg_q   <= sel_reg_d;
            preco_reg_q <= preco_reg_d;
            troco_reg_q <= troco_reg_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        sel_reg_d   = sel_reg_q;
        preco_reg_d = preco_reg_q;
        troco_reg_d = troco_reg_q;
        cnt_d       = cnt_q;
        case (estado_q)
            S_IDLE: begin
                if (cancela) begin
                    estado_d = S_REFUND;
                end else if (confirma) begin
                    sel_reg_d   = sel;
                    preco_reg_d = preco_de(sel);
                    estado_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (total >= preco_reg_q) begin
                    troco_reg_d = total - preco_reg_q;
                    estado_d    = S_DISPENSE;
                end else begin
                    estado_d = S_ERROR;
                end
            end
            S_DISPENSE: begin
                if (cnt_q == DISP_FIM) begin
                    cnt_d    = '0;
                    estado_d = S_CHANGE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_REFUND: begin
                troco_reg_d = total;
                estado_d    = S_CHANGE;
            end
            S_CHANGE: estado_d = S_CLEAR;
            S_CLEAR:  estado_d = S_IDLE;
            S_ERROR: begin
                // A refund request aborts the error wait; credit is still intact.
                if (cancela) begin
                    cnt_d    = '0;
                    estado_d = S_REFUND;
                end else if (cnt_q == ERRO_FIM) begin
                    cnt_d    = '0;
                    estado_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: estado_d = S_IDLE;
        endcase
    end

    always_comb begin
        libera       = '0;
        troco        = '0;
        troco_valido = 1'b0;
        limpa_acum   = 1'b0;
        erro_saldo   = 1'b0;
        ocupado      = (estado_q != S_IDLE);
        case (estado_q)
            S_DISPENSE: libera = 4'b0001 << sel_reg_q;
            S_CHANGE: begin
                troco        = troco_reg_q;
                troco_valido = 1'b1;
            end
            S_CLEAR: limpa_acum = 1'b1;
            S_ERROR: erro_saldo = 1'b1;
            default: ;
        endcase
    end

endmodule
